// File: rtl/wgt_fifo_bank_if.sv
// Bus bundle for wgt_fifo_bank: write/clear controls, per-lane reads, status flags.
// Error-flag signals exist only when WGT_FIFO_ERR_FLAG_EN is defined.
interface wgt_fifo_bank_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_FIFO   = 16,
  parameter int DEPTH      = 4608
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LANE_W = $clog2(NUM_FIFO + 1);

  logic                           wr_clr;
  logic                           rd_clr;
  logic                           wr_en;
  logic [LANE_W-1:0]              active_lanes;
  logic [DATA_WIDTH*NUM_FIFO-1:0] data_in;
  logic [NUM_FIFO-1:0]            rd_en;
  logic [DATA_WIDTH*NUM_FIFO-1:0] data_out;
  logic [NUM_FIFO-1:0]            valid_out;
  logic                           full;
  logic [NUM_FIFO-1:0]            empty;
  logic [ADDR_W:0]                wr_count;

`ifdef WGT_FIFO_ERR_FLAG_EN
  logic                           ovf_err;
  logic [NUM_FIFO-1:0]            udf_err;

  modport master (
    output wr_clr, rd_clr, wr_en, active_lanes, data_in, rd_en,
    input  data_out, valid_out, full, empty, wr_count, ovf_err, udf_err
  );
  modport slave (
    input  wr_clr, rd_clr, wr_en, active_lanes, data_in, rd_en,
    output data_out, valid_out, full, empty, wr_count, ovf_err, udf_err
  );
`else
  modport master (
    output wr_clr, rd_clr, wr_en, active_lanes, data_in, rd_en,
    input  data_out, valid_out, full, empty, wr_count
  );
  modport slave (
    input  wr_clr, rd_clr, wr_en, active_lanes, data_in, rd_en,
    output data_out, valid_out, full, empty, wr_count
  );
`endif
endinterface

// File: rtl/wgt_fifo_bank.sv
// Weight buffer bank: NUM_FIFO lanes, shared write pointer, per-lane read pointers with rewind.
// Read data 1 cycle after accepted rd_en; writes when full / reads when empty are dropped. Option: WGT_FIFO_ERR_FLAG_EN.
module wgt_fifo_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4608,
  parameter int NUM_FIFO   = 16
) (
  input logic            clk,
  input logic            rst_n,
  wgt_fifo_bank_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LANE_W = $clog2(NUM_FIFO + 1);
  localparam int PTR_W  = ADDR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

  logic [PTR_W-1:0]               wr_ptr;
  logic [PTR_W-1:0]               wr_ptr_nxt;
  logic                           full_q;
  logic                           any_clr;
  logic                           wr_acc;
  logic                           all_lanes;
  logic [NUM_FIFO-1:0]            empty_vec;
  logic [NUM_FIFO-1:0]            valid_vec;
  logic [DATA_WIDTH*NUM_FIFO-1:0] dout_vec;

  // Either clear suppresses every access in the same cycle.
  assign any_clr   = bus.wr_clr | bus.rd_clr;
  assign wr_acc    = bus.wr_en & ~full_q & ~any_clr;
  assign all_lanes = (bus.active_lanes == '0) || (bus.active_lanes > LANE_W'(NUM_FIFO));

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    if (bus.wr_clr)
      wr_ptr_nxt = '0;
    else if (wr_acc)
      wr_ptr_nxt = wr_ptr + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      full_q <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      full_q <= (wr_ptr_nxt == DEPTH_P);
    end
  end

  for (genvar i = 0; i < NUM_FIFO; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [DATA_WIDTH-1:0] dout_q;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_ptr_nxt;
    logic                  rd_acc;
    logic                  valid_q;
    logic                  empty_q;

    assign wr_dat = (all_lanes || (LANE_W'(i) < bus.active_lanes)) ?
                    bus.data_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign rd_acc = bus.rd_en[i] & ~empty_q & ~any_clr;

    always_comb begin
      rd_ptr_nxt = rd_ptr;
      if (any_clr)
        rd_ptr_nxt = '0;
      else if (rd_acc)
        rd_ptr_nxt = rd_ptr + PTR_W'(1);
    end

    // Storage has no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
      if (wr_acc)
        mem[wr_ptr[ADDR_W-1:0]] <= wr_dat;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_ptr  <= '0;
        empty_q <= 1'b1;
        valid_q <= 1'b0;
        dout_q  <= '0;
      end else begin
        rd_ptr  <= rd_ptr_nxt;
        empty_q <= (rd_ptr_nxt == wr_ptr_nxt);
        valid_q <= rd_acc;
        if (rd_acc)
          dout_q <= mem[rd_ptr[ADDR_W-1:0]];
      end
    end

    assign empty_vec[i]                          = empty_q;
    assign valid_vec[i]                          = valid_q;
    assign dout_vec[i*DATA_WIDTH +: DATA_WIDTH]  = dout_q;
  end

  assign bus.full      = full_q;
  assign bus.empty     = empty_vec;
  assign bus.valid_out = valid_vec;
  assign bus.data_out  = dout_vec;
  assign bus.wr_count  = wr_ptr;

`ifdef WGT_FIFO_ERR_FLAG_EN
  logic                ovf_q;
  logic [NUM_FIFO-1:0] udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= '0;
    end else if (bus.wr_clr) begin
      ovf_q <= 1'b0;
      udf_q <= '0;
    end else begin
      if (bus.wr_en && full_q)
        ovf_q <= 1'b1;
      udf_q <= udf_q | (bus.rd_en & empty_vec);
    end
  end

  assign bus.ovf_err = ovf_q;
  assign bus.udf_err = udf_q;
`endif
endmodule
